snake_mover: RTL and testbench
==============================

Name: snake_mover

Overview:
- Owns one snake's body and produces the packed segment array that the collision checker reads.
- Advances the snake by one grid cell per game tick, applies direction requests and growth requests, and freezes when the collision logic raises stop.
- One instance per player; its `snake` output feeds the checker and the VGA renderer.

Parameters:
- TICK_DIV, 25000000, clk cycles per game step; minimum 2.
- INIT_X, 5, head column after reset/start; range 2..30.
- INIT_Y, 10, head row after reset/start; range 0..31.
- INIT_LEN, 3, segment count after reset/start; range 1..16, INIT_X-INIT_LEN+1 >= 0.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; (re)initialises the snake and enters RUN.
- dir_in  input  2  requested direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1).
- dir_valid  input  1  qualifies dir_in for one cycle.
- grow  input  1  one-cycle pulse; snake gains one segment at the next step.
- stop  input  1  level from collision_check; freezes the snake.
- snake  output  [15:0][9:0]  segment positions {y[4:0],x[4:0]}; [0] is the head.
- length  output  5  active segment count, 1..16.
- step  output  1  one-cycle pulse in the cycle after the segments move.
- running  output  1  high in RUN.

Behaviour:
- Grid: x 0..30, y 0..31. Column x=31 is never on the board. Inactive segments (index >= length) hold 10'h3FF, so they never match a real head.
- Reset (async, rst_n=0) and start apply the same initial state:
  - seg[i] = {INIT_Y, INIT_X-i} for i < INIT_LEN; the rest are 10'h3FF.
  - length = INIT_LEN; current dir = right.
  - Pending dir cleared, pending grow cleared, tick counter 0, step=0.
- Reset state is IDLE with running=0. start additionally moves to RUN.
- States:
  - IDLE -> RUN on start.
  - RUN -> STOPPED when stop=1.
  - STOPPED -> RUN on start (with reinit).
  - start while in RUN reinitialises and stays in RUN.
- Tick counter runs only in RUN, 0..TICK_DIV-1, and wraps. A step occurs on the cycle the counter is at TICK_DIV-1.
- Direction:
  - dir_valid latches dir_in into the pending dir; the last request before a step wins.
  - At a step, the pending dir becomes current unless it is the exact reversal of current (up/down, left/right). A reversal is discarded and current is kept.
- Step, single clock edge:
  - seg[i] <= seg[i-1] for 1 <= i < length.
  - seg[0] <= head moved one cell in the current dir.
  - Wrap-around: x 30->0 going right, x 0->30 going left, y 31->0 going down, y 0->31 going up.
- Growth:
  - grow sets a sticky pending flag.
  - At the next step, if length < 16: seg[length] <= old seg[length-1] and length increments.
  - At length 16, the grow is dropped.
  - Pending grow clears at that step in both cases.
  - grow arriving in the same cycle as a step applies at the following step.
- step pulses high exactly one cycle after each move edge.
- stop and step in the same cycle: stop wins; no move, no length change, no step pulse.
- In STOPPED, segments and length hold, the counter holds at 0, and dir_valid and grow are ignored.

Optional Feature:
- Macro SNAKE_SOLID_WALL_EN.
- Defined:
  - Adds an output port `hit_wall` (1 bit, reset 0).
  - A step whose head would cross the board edge (wrap condition) does not move. Instead, hit_wall is set sticky and the FSM enters STOPPED.
  - start clears hit_wall.
- Undefined: wrap-around as described above, and no hit_wall port.

Test Plan:
- Reset with defaults -> snake[0]=={10,5}, [1]=={10,4}, [2]=={10,3}, [3..15]==10'h3FF, length=3, running=0.
- TICK_DIV=4, start, no input -> after 4 cycles step pulses and head={10,6}, [2]={10,4}; no move before that.
- Head at x=30 moving right, step -> head x=0. Moving up from y=0 -> y=31.
- Current dir right, dir_valid with dir_in=10 (left) -> ignored, head x+1. Then dir_in=00 -> next step head y-1.
- grow pulse from length 3 -> next step length=4, seg[3]=old seg[2]. Repeat grow 14 times -> length saturates at 16 and the extra grow is dropped.
- stop asserted on the step cycle -> no move, state STOPPED, step=0. rst_n dropped mid-run -> outputs return to reset values immediately.

Source files
------------

// File: rtl/snake_mover.sv
// Snake body owner: advances one cell per game tick, applies turn/grow requests, freezes on stop.
// Optional SNAKE_SOLID_WALL_EN: board edges become solid and raise sticky hit_wall instead of wrapping.
module snake_mover #(
    parameter int TICK_DIV = 25000000,
    parameter int INIT_X   = 5,
    parameter int INIT_Y   = 10,
    parameter int INIT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       dir_in,
    input  logic             dir_valid,
    input  logic             grow,
    input  logic             stop,
    output logic [15:0][9:0] snake,
    output logic [4:0]       length,
    output logic             step,
    output logic             running
`ifdef SNAKE_SOLID_WALL_EN
    ,
    output logic             hit_wall
`endif
);

    // state   | meaning
    // S_IDLE  | after reset, waiting for start
    // S_RUN   | tick counter running, snake moves every TICK_DIV cycles
    // S_STOP  | frozen by stop (or wall hit); only start leaves
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);
    localparam logic [1:0] DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b11;

`ifdef SNAKE_SOLID_WALL_EN
    localparam bit WALL = 1'b1;
`else
    localparam bit WALL = 1'b0;
`endif

    function automatic logic [15:0][9:0] init_seg();
        logic [15:0][9:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = (i < INIT_LEN) ? {5'(INIT_Y), 5'(INIT_X - i)} : 10'h3FF;
        end
        return r;
    endfunction

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [1:0]    cur_dir, pend_dir, new_dir;
    logic          pend_v, grow_p, grow_ok;
    logic          tick, do_init, do_step, do_hit, wrap;
    logic [4:0]    hx, hy, nx, ny;

    assign tick    = (cnt == TC);
    assign running = (state == S_RUN);
    assign grow_ok = grow_p && (length != 5'd16);

    // Turn resolution and next head; reversal of the current heading is discarded.
    always_comb begin
        new_dir = cur_dir;
        if (pend_v && (pend_dir != (cur_dir ^ 2'b01))) new_dir = pend_dir;
        hx   = snake[0][4:0];
        hy   = snake[0][9:5];
        nx   = hx;
        ny   = hy;
        wrap = 1'b0;
        case (new_dir)
            DIR_UP:   begin ny = hy - 5'd1; wrap = (hy == 5'd0);  end
            DIR_DOWN: begin ny = hy + 5'd1; wrap = (hy == 5'd31); end
            DIR_LEFT: begin nx = (hx == 5'd0) ? 5'd30 : hx - 5'd1; wrap = (hx == 5'd0); end
            default:  begin nx = (hx == 5'd30) ? 5'd0 : hx + 5'd1; wrap = (hx == 5'd30); end
        endcase
    end

    always_comb begin
        state_nx = state;
        do_init  = 1'b0;
        do_step  = 1'b0;
        do_hit   = 1'b0;
        case (state)
            S_IDLE: if (start) begin state_nx = S_RUN; do_init = 1'b1; end
            S_RUN: begin
                if (start) begin
                    do_init = 1'b1;
                end else if (stop) begin
                    state_nx = S_STOP;
                end else if (tick) begin
                    if (WALL && wrap) begin
                        do_hit   = 1'b1;
                        state_nx = S_STOP;
                    end else begin
                        do_step = 1'b1;
                    end
                end
            end
            S_STOP: if (start) begin state_nx = S_RUN; do_init = 1'b1; end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snake    <= init_seg();
            length   <= 5'(INIT_LEN);
            cur_dir  <= DIR_RIGHT;
            pend_dir <= DIR_RIGHT;
            pend_v   <= 1'b0;
            grow_p   <= 1'b0;
            cnt      <= '0;
            step     <= 1'b0;
        end else begin
            step <= do_step;
            if (do_init) begin
                snake    <= init_seg();
                length   <= 5'(INIT_LEN);
                cur_dir  <= DIR_RIGHT;
                pend_dir <= DIR_RIGHT;
                pend_v   <= 1'b0;
                grow_p   <= 1'b0;
                cnt      <= '0;
            end else if (state == S_RUN) begin
                if (state_nx == S_RUN) cnt <= tick ? '0 : cnt + 1'b1;
                else                   cnt <= '0;
                if (do_step || do_hit) begin
                    cur_dir <= new_dir;
                    pend_v  <= 1'b0;
                    grow_p  <= 1'b0;
                end
                if (do_step) begin
                    snake[0] <= {ny, nx};
                    // Growth extends the shift by one slot, duplicating the old tail.
                    for (int i = 1; i < 16; i++) begin
                        if ((5'(i) < length) || ((5'(i) == length) && grow_ok))
                            snake[i] <= snake[i-1];
                    end
                    if (grow_ok) length <= length + 5'd1;
                end
                // Requests in a step cycle land after the step clears, so they apply next time.
                if (dir_valid) begin
                    pend_dir <= dir_in;
                    pend_v   <= 1'b1;
                end
                if (grow) grow_p <= 1'b1;
            end
        end
    end

`ifdef SNAKE_SOLID_WALL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       hit_wall <= 1'b0;
        else if (do_init) hit_wall <= 1'b0;
        else if (do_hit)  hit_wall <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_snake_mover.sv
// Self-checking bench for snake_mover: directed scenarios plus randomized run against a queue-based model.
module tb_snake_mover;
    localparam int TD = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       dir_in = 2'b00;
    logic             dir_valid = 1'b0;
    logic             grow = 1'b0;
    logic             stop = 1'b0;
    logic [15:0][9:0] snake;
    logic [4:0]       length;
    logic             step;
    logic             running;
`ifdef SNAKE_SOLID_WALL_EN
    logic             hit_wall;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: body as coordinate queues, head at index 0.
    int bx[$];
    int by[$];
    int mstate;           // 0 idle, 1 run, 2 stopped
    int mcnt, mdir, mpdir;
    bit mpv, mgrow, mstep;

    snake_mover #(.TICK_DIV(TD), .INIT_X(5), .INIT_Y(10), .INIT_LEN(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir_in(dir_in),
        .dir_valid(dir_valid), .grow(grow), .stop(stop), .snake(snake),
        .length(length), .step(step), .running(running)
`ifdef SNAKE_SOLID_WALL_EN
        , .hit_wall(hit_wall)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_init();
        bx.delete();
        by.delete();
        for (int i = 0; i < 3; i++) begin
            bx.push_back(5 - i);
            by.push_back(10);
        end
        mdir = 3; mpdir = 3; mpv = 0; mgrow = 0; mcnt = 0;
    endtask

    task automatic model_update(input bit st, input bit dv, input int d, input bit gr, input bit sp);
        bit stepped = 0;
        if (st) begin
            model_init();
            mstate = 1;
        end else if (mstate == 1) begin
            if (sp) begin
                mstate = 2;
                mcnt = 0;
            end else begin
                if (mcnt == TD - 1) begin
                    int dx, dy, nxp, nyp;
                    mcnt = 0;
                    if (mpv && !((mpdir == 0 && mdir == 1) || (mpdir == 1 && mdir == 0) ||
                                 (mpdir == 2 && mdir == 3) || (mpdir == 3 && mdir == 2)))
                        mdir = mpdir;
                    dx = (mdir == 2) ? -1 : (mdir == 3) ? 1 : 0;
                    dy = (mdir == 0) ? -1 : (mdir == 1) ? 1 : 0;
                    nxp = (bx[0] + dx + 31) % 31;
                    nyp = (by[0] + dy + 32) % 32;
                    bx.push_front(nxp);
                    by.push_front(nyp);
                    if (!(mgrow && bx.size() <= 16)) begin
                        void'(bx.pop_back());
                        void'(by.pop_back());
                    end
                    mgrow = 0;
                    mpv = 0;
                    stepped = 1;
                end else begin
                    mcnt++;
                end
                if (dv) begin mpdir = d; mpv = 1; end
                if (gr) mgrow = 1;
            end
        end
        mstep = stepped;
    endtask

    task automatic do_cycle(input bit st, input bit dv, input logic [1:0] d, input bit gr, input bit sp);
        start = st; dir_valid = dv; dir_in = d; grow = gr; stop = sp;
        @(posedge clk);
        model_update(st, dv, int'(d), gr, sp);
        #1;
        start = 0; dir_valid = 0; grow = 0; stop = 0;
    endtask

    task automatic run_cyc(input int n);
        for (int k = 0; k < n; k++) do_cycle(0, 0, 2'b00, 0, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0;
        model_init();
        mstate = 0; mstep = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        apply_reset();
        rst_n = 0;
        #1;
        for (int i = 0; i < 16; i++) begin
            exp = (i < 3) ? 10'((10 << 5) | (5 - i)) : 10'h3FF;
            checks++;
            if (snake[i] !== exp) begin
                failures++;
                $display("FAIL reset_seg%0d got=%h want=%h", i, snake[i], exp);
            end
        end
        checks++;
        if (length !== 5'd3) begin failures++; $display("FAIL reset_len got=%0d want=3", length); end
        checks++;
        if (running !== 1'b0 || step !== 1'b0) begin
            failures++; $display("FAIL reset_flags running=%b step=%b want 0 0", running, step);
        end
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_step();
        apply_reset();
        do_cycle(1, 0, 2'b00, 0, 0);
        checks++;
        if (running !== 1'b1) begin failures++; $display("FAIL start_running got=%b want=1", running); end
        for (int k = 1; k < TD; k++) begin
            do_cycle(0, 0, 2'b00, 0, 0);
            checks++;
            if (snake[0] !== 10'h145 || step !== 1'b0) begin
                failures++; $display("FAIL early_move cyc=%0d head=%h step=%b want 145 0", k, snake[0], step);
            end
        end
        do_cycle(0, 0, 2'b00, 0, 0);
        checks++;
        if (step !== 1'b1 || snake[0] !== 10'h146 || snake[2] !== 10'h144) begin
            failures++;
            $display("FAIL first_step step=%b head=%h seg2=%h want 1 146 144", step, snake[0], snake[2]);
        end
        do_cycle(0, 0, 2'b00, 0, 0);
        checks++;
        if (step !== 1'b0) begin failures++; $display("FAIL step_pulse_width got=%b want=0", step); end
    endtask

    task automatic test_wrap();
        apply_reset();
        do_cycle(1, 0, 2'b00, 0, 0);
        run_cyc(TD * 26);
        checks++;
        if (snake[0] !== 10'h140) begin failures++; $display("FAIL wrap_right head=%h want=140", snake[0]); end
        do_cycle(0, 1, 2'b00, 0, 0);
        run_cyc(TD * 11 - 1);
        checks++;
        if (snake[0] !== 10'h3E0) begin failures++; $display("FAIL wrap_up head=%h want=3e0", snake[0]); end
    endtask

    task automatic test_reversal();
        apply_reset();
        do_cycle(1, 0, 2'b00, 0, 0);
        do_cycle(0, 1, 2'b10, 0, 0);
        run_cyc(TD - 1);
        checks++;
        if (snake[0] !== 10'h146) begin failures++; $display("FAIL reversal_ignored head=%h want=146", snake[0]); end
        do_cycle(0, 1, 2'b00, 0, 0);
        run_cyc(TD - 1);
        checks++;
        if (snake[0] !== 10'h126) begin failures++; $display("FAIL turn_up head=%h want=126", snake[0]); end
    endtask

    task automatic test_grow();
        logic [9:0] exp;
        apply_reset();
        do_cycle(1, 0, 2'b00, 0, 0);
        do_cycle(0, 0, 2'b00, 1, 0);
        run_cyc(TD - 1);
        checks++;
        if (length !== 5'd4 || snake[3] !== 10'h143 || snake[0] !== 10'h146) begin
            failures++;
            $display("FAIL grow_once len=%0d seg3=%h head=%h want 4 143 146", length, snake[3], snake[0]);
        end
        for (int k = 0; k < 14; k++) begin
            do_cycle(0, 0, 2'b00, 1, 0);
            run_cyc(TD - 1);
        end
        exp = 10'((by[15] << 5) | bx[15]);
        checks++;
        if (length !== 5'd16 || snake[15] !== exp) begin
            failures++; $display("FAIL grow_saturate len=%0d seg15=%h want 16 %h", length, snake[15], exp);
        end
    endtask

    task automatic test_stop();
        apply_reset();
        do_cycle(1, 0, 2'b00, 0, 0);
        run_cyc(TD - 1);
        do_cycle(0, 0, 2'b00, 0, 1);
        checks++;
        if (snake[0] !== 10'h145 || step !== 1'b0 || running !== 1'b0) begin
            failures++;
            $display("FAIL stop_on_step head=%h step=%b running=%b want 145 0 0", snake[0], step, running);
        end
        do_cycle(0, 1, 2'b00, 1, 0);
        run_cyc(8);
        checks++;
        if (snake[0] !== 10'h145 || length !== 5'd3) begin
            failures++; $display("FAIL stopped_hold head=%h len=%0d want 145 3", snake[0], length);
        end
        do_cycle(1, 0, 2'b00, 0, 0);
        run_cyc(TD);
        checks++;
        if (running !== 1'b1 || snake[0] !== 10'h146 || length !== 5'd3) begin
            failures++;
            $display("FAIL restart running=%b head=%h len=%0d want 1 146 3", running, snake[0], length);
        end
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        do_cycle(1, 0, 2'b00, 0, 0);
        do_cycle(0, 0, 2'b00, 1, 0);
        run_cyc(TD - 1);
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (snake[0] !== 10'h145 || snake[3] !== 10'h3FF || length !== 5'd3 || step !== 1'b0 || running !== 1'b0) begin
            failures++;
            $display("FAIL async_reset head=%h seg3=%h len=%0d step=%b run=%b", snake[0], snake[3], length, step, running);
        end
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [9:0] exp;
        bit st, dv, gr, sp, bad;
        apply_reset();
        do_cycle(1, 0, 2'b00, 0, 0);
        for (int c = 0; c < 800; c++) begin
            st = ($urandom % 150 == 0) || (mstate == 2 && $urandom % 6 == 0);
            sp = ($urandom % 60 == 0);
            dv = ($urandom % 3 == 0);
            gr = ($urandom % 5 == 0);
            do_cycle(st, dv, 2'($urandom % 4), gr, sp);
            bad = 0;
            for (int i = 0; i < 16; i++) begin
                exp = (i < bx.size()) ? 10'((by[i] << 5) | bx[i]) : 10'h3FF;
                if (snake[i] !== exp) bad = 1;
            end
            checks++;
            if (bad) begin
                failures++; $display("FAIL rand_snake cyc=%0d head=%h want_head=%h", c, snake[0], 10'((by[0] << 5) | bx[0]));
            end
            checks++;
            if (length !== 5'(bx.size())) begin
                failures++; $display("FAIL rand_len cyc=%0d got=%0d want=%0d", c, length, bx.size());
            end
            checks++;
            if (step !== mstep || running !== (mstate == 1)) begin
                failures++;
                $display("FAIL rand_flags cyc=%0d step=%b running=%b want %b %b", c, step, running, mstep, mstate == 1);
            end
        end
    endtask

    initial begin
        model_init();
        mstate = 0;
        test_reset();
        test_first_step();
        test_wrap();
        test_reversal();
        test_grow();
        test_stop();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
